// File: rtl/rsa_word_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : rsa_word_deser_if
// Description : Host-side bus bundle for the RSA word deserializer.
//               msw_first exists only when S2P_DIR_SEL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rsa_word_deser_if #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32
);
    localparam int NWORDS = RSA_LEN / BUS_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    logic               start;
    logic               abort;
    logic               in_vld;
    logic               in_rdy;
    logic [BUS_W-1:0]   data_in;
`ifdef S2P_DIR_SEL_EN
    logic               msw_first;
`endif
    logic [RSA_LEN-1:0] data_out;
    logic               out_vld;
    logic               busy;
    logic [CNT_W-1:0]   word_cnt;

`ifdef S2P_DIR_SEL_EN
    modport master (
        output start, abort, in_vld, data_in, msw_first,
        input  in_rdy, data_out, out_vld, busy, word_cnt
    );
    modport slave (
        input  start, abort, in_vld, data_in, msw_first,
        output in_rdy, data_out, out_vld, busy, word_cnt
    );
`else
    modport master (
        output start, abort, in_vld, data_in,
        input  in_rdy, data_out, out_vld, busy, word_cnt
    );
    modport slave (
        input  start, abort, in_vld, data_in,
        output in_rdy, data_out, out_vld, busy, word_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rsa_word_deser.sv
`default_nettype none
// ============================================================================
// Module      : rsa_word_deser
// Description : Word-serial to operand-parallel deserializer with valid/ready
//               flow control, start/abort and a completion pulse.
//               Optional macro S2P_DIR_SEL_EN adds per-capture word order.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_word_deser #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32
) (
    input  wire              clk,
    input  wire              rst,
    rsa_word_deser_if.slave  bus
);
    localparam int NWORDS = RSA_LEN / BUS_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [RSA_LEN-1:0] r_data;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               w_msw;
    logic               w_accept;
    logic               w_last;

    // Abort wins over a coincident word, so the word never reaches the shifter.
    assign w_accept = (r_state == S_LOAD) && bus.in_vld && !bus.abort;
    assign w_last   = w_accept && (r_word_cnt == CNT_W'(NWORDS - 1));

`ifdef S2P_DIR_SEL_EN
    logic r_msw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msw <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_msw <= bus.msw_first;
        end
    end

    assign w_msw = r_msw;
`else
    assign w_msw = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD: begin
                if (bus.abort)   w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_word_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_word_cnt <= '0;
            end
            if (r_state == S_LOAD && bus.abort) begin
                r_word_cnt <= '0;
            end
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                if (w_msw) begin
                    r_data <= {r_data[RSA_LEN-BUS_W-1:0], bus.data_in};
                end else begin
                    r_data <= {bus.data_in, r_data[RSA_LEN-1:BUS_W]};
                end
            end
        end
    end

    assign bus.in_rdy   = (r_state == S_LOAD);
    assign bus.busy     = (r_state == S_LOAD);
    assign bus.out_vld  = (r_state == S_DONE);
    assign bus.data_out = r_data;
    assign bus.word_cnt = r_word_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rsa_word_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_word_deser
// Description : Self-checking bench for rsa_word_deser (512/32 configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_word_deser;
    localparam int RSA_LEN = 512;
    localparam int BUS_W   = 32;
    localparam int NWORDS  = RSA_LEN / BUS_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rsa_word_deser_if #(.RSA_LEN(RSA_LEN), .BUS_W(BUS_W)) bus ();
    rsa_word_deser #(.RSA_LEN(RSA_LEN), .BUS_W(BUS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors    = 0;
    int checks    = 0;
    int ov_pulses = 0;
    logic [RSA_LEN-1:0] m_data;

    typedef struct {
        logic               st;
        logic               ab;
        logic               vld;
        logic [BUS_W-1:0]   d;
        logic               rdy;
        logic               bsy;
        logic               ov;
        int                 cnt;
        logic [RSA_LEN-1:0] dat;
    } vec_t;
    vec_t tbl [8];

    always @(negedge clk) if (bus.out_vld === 1'b1) ov_pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [RSA_LEN-1:0] act, input logic [RSA_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic ov, input int cnt);
        chk({tag, ".in_rdy"},   RSA_LEN'(bus.in_rdy),   RSA_LEN'(rdy));
        chk({tag, ".busy"},     RSA_LEN'(bus.busy),     RSA_LEN'(bsy));
        chk({tag, ".out_vld"},  RSA_LEN'(bus.out_vld),  RSA_LEN'(ov));
        chk({tag, ".word_cnt"}, RSA_LEN'(bus.word_cnt), RSA_LEN'(cnt));
    endtask

    task automatic set_msw(input logic m);
`ifdef S2P_DIR_SEL_EN
        bus.msw_first = m;
`else
        if (m === 1'bx) $display("msw select unknown");
`endif
    endtask

    // Reference: the i-th word of a capture lands in slot i (LSW-first) or
    // slot NWORDS-1-i (MSW-first) of the finished operand.
    function automatic logic [RSA_LEN-1:0] assemble(input logic [BUS_W-1:0] w [NWORDS], input logic msw);
        logic [RSA_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (msw) r[(NWORDS-1-i)*BUS_W +: BUS_W] = w[i];
            else     r[i*BUS_W +: BUS_W] = w[i];
        end
        return r;
    endfunction

    // One transaction: start, NWORDS words with gaps (gap<0 = random 0..3),
    // optional abort on word abort_at, optional noise on start/msw_first.
    task automatic run_capture(input logic msw, input int gap, input int abort_at, input bit noise, input bit seq);
        logic [BUS_W-1:0] w [NWORDS];
        logic eff_msw;
        int g;
`ifdef S2P_DIR_SEL_EN
        eff_msw = msw;
`else
        eff_msw = 1'b0;
`endif
        for (int i = 0; i < NWORDS; i++) w[i] = seq ? BUS_W'(32'hA + i) : BUS_W'($urandom);
        bus.start = 1'b1; set_msw(msw); bus.in_vld = 1'b0;
        step();
        bus.start = 1'b0;
        chk_ctl("cap_start", 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < NWORDS; i++) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            for (int k = 0; k < g; k++) begin
                bus.in_vld = 1'b0; bus.data_in = BUS_W'($urandom);
                if (noise) begin
                    bus.start = 1'($urandom_range(1, 0));
                    set_msw(1'($urandom_range(1, 0)));
                end
                step();
                bus.start = 1'b0;
                chk_ctl("cap_stall", 1'b1, 1'b1, 1'b0, i);
            end
            bus.in_vld = 1'b1; bus.data_in = w[i]; bus.abort = (i == abort_at);
            if (noise) set_msw(1'($urandom_range(1, 0)));
            step();
            bus.in_vld = 1'b0; bus.abort = 1'b0;
            if (i == abort_at) begin
                chk_ctl("cap_abort", 1'b0, 1'b0, 1'b0, 0);
                step();
                chk_ctl("cap_post_abort", 1'b0, 1'b0, 1'b0, 0);
                return;
            end
            if (i < NWORDS - 1) chk_ctl("cap_word", 1'b1, 1'b1, 1'b0, i + 1);
        end
        m_data = assemble(w, eff_msw);
        chk_ctl("cap_done", 1'b0, 1'b0, 1'b1, NWORDS);
        chk("cap_data", bus.data_out, m_data);
        if (noise) begin
            bus.start = 1'b1; bus.abort = 1'b1;
        end
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk_ctl("cap_idle", 1'b0, 1'b0, 1'b0, NWORDS);
        chk("cap_hold", bus.data_out, m_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUS_W-1:0] zw [NWORDS];
        logic [RSA_LEN-1:0] d0, d1, d2;
        int cyc, idx, p0;

        // Vectors start right after a zero-stall capture of words 0..NWORDS-1.
        for (int i = 0; i < NWORDS; i++) zw[i] = BUS_W'(i);
        d0 = assemble(zw, 1'b0);
        d1 = (d0 >> BUS_W) | (RSA_LEN'(32'h100) << (RSA_LEN - BUS_W));
        d2 = (d1 >> BUS_W) | (RSA_LEN'(32'h101) << (RSA_LEN - BUS_W));
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, NWORDS, d0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h55,  1'b0, 1'b0, 1'b0, NWORDS, d0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 0,      d0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h77,  1'b1, 1'b1, 1'b0, 0,      d0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1,      d1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h101, 1'b1, 1'b1, 1'b0, 2,      d2};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 0,      d2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 0,      d2};

        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_vld = 1'b0; bus.data_in = '0;
        set_msw(1'b0);
        m_data = '0;
        step(); step();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset.data_out", bus.data_out, '0);
        rst = 1'b0;
        step();
        chk_ctl("idle", 1'b0, 1'b0, 1'b0, 0);

        // Zero-stall capture: out_vld must appear in cycle start+NWORDS+1.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1; idx = 0;
        while (bus.out_vld !== 1'b1 && cyc < 40) begin
            bus.in_vld = (idx < NWORDS); bus.data_in = BUS_W'(idx);
            step();
            if (idx < NWORDS) idx++;
            cyc++;
        end
        bus.in_vld = 1'b0;
        chk("zs_latency", RSA_LEN'(cyc), RSA_LEN'(NWORDS + 1));
        chk("zs_low_word", RSA_LEN'(bus.data_out[31:0]), RSA_LEN'(32'h0));
        chk("zs_high_word", RSA_LEN'(bus.data_out[511:480]), RSA_LEN'(32'hF));
        chk("zs_data", bus.data_out, d0);
        chk("zs_cnt", RSA_LEN'(bus.word_cnt), RSA_LEN'(NWORDS));
        step();
        chk_ctl("zs_idle", 1'b0, 1'b0, 1'b0, NWORDS);

        // Cycle-level vectors: IDLE abort/valid, start+abort, LOAD start, abort priority.
        for (int r = 0; r < 8; r++) begin
            bus.start = tbl[r].st; bus.abort = tbl[r].ab;
            bus.in_vld = tbl[r].vld; bus.data_in = tbl[r].d;
            set_msw(1'b0);
            step();
            chk_ctl($sformatf("tbl%0d", r), tbl[r].rdy, tbl[r].bsy, tbl[r].ov, tbl[r].cnt);
            chk($sformatf("tbl%0d.data_out", r), bus.data_out, tbl[r].dat);
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_vld = 1'b0;

        // Full capture after an abort.
        run_capture(1'b0, 0, -1, 1'b0, 1'b0);

        // Fixed 3-cycle gaps with words 0xA, 0xB, ... and a single pulse.
        p0 = ov_pulses;
        run_capture(1'b0, 3, -1, 1'b0, 1'b1);
        chk("stall_pulses", RSA_LEN'(ov_pulses - p0), RSA_LEN'(1));

        // start pulses in LOAD and DONE, abort in DONE: all ignored.
        p0 = ov_pulses;
        run_capture(1'b0, -1, -1, 1'b1, 1'b0);
        chk("noise_pulses", RSA_LEN'(ov_pulses - p0), RSA_LEN'(1));

        // MSW-first with msw_first toggling during LOAD.
        run_capture(1'b1, -1, -1, 1'b1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            run_capture(1'($urandom_range(1, 0)), -1,
                        ($urandom_range(3, 0) == 0) ? int'($urandom_range(NWORDS - 1, 0)) : -1,
                        1'b1, 1'b0);
        end

        // Synchronous reset part-way through a capture.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_vld = 1'b1; bus.data_in = BUS_W'($urandom);
            step();
        end
        chk_ctl("rst_pre", 1'b1, 1'b1, 1'b0, 5);
        rst = 1'b1; bus.data_in = BUS_W'($urandom);
        step();
        rst = 1'b0; bus.in_vld = 1'b0;
        chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 0);
        chk("rst_mid.data_out", bus.data_out, '0);
        p0 = ov_pulses;
        repeat (3) step();
        chk("rst_pulses", RSA_LEN'(ov_pulses - p0), RSA_LEN'(0));
        chk_ctl("rst_after", 1'b0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
